// File: rtl/plic_pkg.sv
// Shared types and helpers for the PLIC gateway slice.
package plic_pkg;

  typedef enum logic [1:0] {
    GW_IDLE    = 2'd0,
    GW_PENDING = 2'd1,
    GW_CLAIMED = 2'd2
  } gw_state_t;

  // ID value meaning "no interrupt".
  localparam int unsigned NO_IRQ = 0;

  // Bits needed to encode IDs 0..n.
  function automatic int id_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/plic_gw_cell.sv
// One interrupt source: synchroniser, edge detector, saved-edge bit and
// IDLE/PENDING/CLAIMED state machine.
module plic_gw_cell
  import plic_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      src,
  input  logic      edge_mode,
  input  logic      claim_hit,
  input  logic      complete_hit,
  output gw_state_t state
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   saved_q, saved_d;
  gw_state_t              state_q, state_d;
  logic                   s, rise, trig;

  assign s     = sync_q[SYNC_STAGES-1];
  assign rise  = s & ~prev_q;
  assign trig  = edge_mode ? rise : s;
  assign state = state_q;

  // Synchroniser chain feeding s, plus the one-cycle delayed sample of s.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], src};
      prev_q <= s;
    end
  end

  // Next state and saved-edge bookkeeping; a rise arriving with the
  // completion is folded straight back into PENDING.
  always_comb begin
    state_d = state_q;
    saved_d = saved_q;
    unique case (state_q)
      GW_IDLE: begin
        if (trig) state_d = GW_PENDING;
      end
      GW_PENDING: begin
        if (claim_hit) state_d = GW_CLAIMED;
        if (edge_mode && rise) saved_d = 1'b1;
      end
      GW_CLAIMED: begin
        if (complete_hit) begin
          if (edge_mode && (saved_q || rise)) begin
            state_d = GW_PENDING;
            saved_d = 1'b0;
          end else begin
            state_d = GW_IDLE;
          end
        end else if (edge_mode && rise) begin
          saved_d = 1'b1;
        end
      end
      default: state_d = GW_IDLE;
    endcase
    // Level-triggered sources never carry a remembered edge.
    if (!edge_mode) saved_d = 1'b0;
  end

  // State and saved-edge registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= GW_IDLE;
      saved_q <= 1'b0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
    end
  end

endmodule

// File: rtl/plic_gateway.sv
// PLIC gateway top: N_SRC source cells, fixed-priority winner selection
// and claim/complete ID decode.
module plic_gateway
  import plic_pkg::*;
#(
  parameter int N_SRC       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int ID_W        = id_width(N_SRC)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_SRC-1:0] src_i,
  input  logic [N_SRC-1:0] edge_mode_i,
  input  logic [N_SRC-1:0] enable_i,
  output logic             irq_o,
  input  logic             claim_i,
  output logic [ID_W-1:0]  claim_id_o,
  input  logic             complete_i,
  input  logic [ID_W-1:0]  complete_id_i,
  output logic [N_SRC-1:0] pending_o
);

  localparam logic [ID_W-1:0] NoIrqId = ID_W'(NO_IRQ);

  gw_state_t        cell_state [N_SRC];
  logic [N_SRC-1:0] claim_hit;
  logic [N_SRC-1:0] complete_hit;
  logic [N_SRC-1:0] active;

  for (genvar k = 0; k < N_SRC; k++) begin : g_src
    // Source k answers to ID k+1; IDs 0 and above N_SRC match nothing.
    assign claim_hit[k]    = claim_i && (claim_id_o == ID_W'(k + 1));
    assign complete_hit[k] = complete_i && (complete_id_i == ID_W'(k + 1));

    plic_gw_cell #(
      .SYNC_STAGES (SYNC_STAGES)
    ) u_cell (
      .clk          (clk_i),
      .rst          (rst_i),
      .src          (src_i[k]),
      .edge_mode    (edge_mode_i[k]),
      .claim_hit    (claim_hit[k]),
      .complete_hit (complete_hit[k]),
      .state        (cell_state[k])
    );
  end

  // Unmasked pending flags and the enabled subset used for arbitration.
  always_comb begin
    pending_o = '0;
    for (int k = 0; k < N_SRC; k++) begin
      pending_o[k] = (cell_state[k] == GW_PENDING);
    end
    active = pending_o & enable_i;
    irq_o  = |active;
  end

  // Fixed priority: lowest index among enabled pending sources wins.
  always_comb begin
    claim_id_o = NoIrqId;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (active[k]) claim_id_o = ID_W'(k + 1);
    end
  end

endmodule
